// File: rtl/dmem_stall_resp_pkg.sv
`default_nettype none
// ============================================================================
// dmem_stall_resp_pkg : shared types and helpers for the data-memory responder
// Revision 1.0
// ============================================================================
package dmem_stall_resp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_stall_resp_array.sv
`default_nettype none
// ============================================================================
// dmem_array : single-port byte-enable RAM, registered read, no reset
// Revision 1.0
// ============================================================================
module dmem_array
    import dmem_stall_resp_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic                        clk,
    input  logic                        en,
    input  logic                        we,
    input  logic [be_width(DATA_W)-1:0] be,
    input  logic [IDX_W-1:0]            idx,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata
);

    localparam int BE_W = be_width(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_stall_resp.sv
`default_nettype none
// ============================================================================
// dmem_stall_resp : fixed-latency data-memory responder driving the CPU stall
// Revision 1.0
// ============================================================================
module dmem_stall_resp
    import dmem_stall_resp_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [be_width(DATA_W)-1:0] req_be,
    output logic                        stall,
    output logic                        resp_valid,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        resp_err
);

    localparam int BE_W  = be_width(DATA_W);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (LATENCY < 1) begin : g_latency_check
        $fatal(1, "dmem_stall_resp: LATENCY must be at least 1");
    end

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [BE_W-1:0]   cap_be;

    logic              err_q;
    logic              load_ok_q;
    logic [DATA_W-1:0] rdata_hold;

    logic              eff_we;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_wdata;
    logic [BE_W-1:0]   eff_be;
    logic              eff_err;
    logic              enter_done;
    logic              ram_en;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] done_rdata;

    // With LATENCY==1 the DONE entry edge is the capture edge, so the live
    // request must feed the RAM and error check directly.
    assign eff_we    = (state == IDLE) ? req_we    : cap_we;
    assign eff_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign eff_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign eff_be    = (state == IDLE) ? req_be    : cap_be;

    assign eff_err = (eff_addr[1:0] != 2'b00) ||
                     ({2'b00, eff_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS));

    assign enter_done = (state != DONE) && (state_nxt == DONE);
    assign ram_en     = enter_done && !eff_err && !rst;

    dmem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (eff_we),
        .be    (eff_be),
        .idx   (eff_addr[IDX_W+1:2]),
        .wdata (eff_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                    state_nxt = (LATENCY > 1) ? WAIT : DONE;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else if (state == IDLE && req_valid) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
        end else if (enter_done) begin
            err_q     <= eff_err;
            load_ok_q <= !eff_we && !eff_err;
        end
    end

    // RAM data only appears during DONE; keep it afterwards until the next completion.
    assign done_rdata = load_ok_q ? ram_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_hold <= '0;
        end else if (state == DONE) begin
            rdata_hold <= done_rdata;
        end
    end

    assign stall      = rst || ((state == IDLE) ? req_valid : (state == WAIT));
    assign resp_valid = (state == DONE);
    assign resp_err   = (state == DONE) && err_q;
    assign resp_rdata = (state == DONE) ? done_rdata : rdata_hold;

endmodule
`default_nettype wire

// File: tb/tb_dmem_stall_resp.sv
`default_nettype none
// ============================================================================
// tb_dmem_stall_resp : directed bench with a transaction-level memory model
// Revision 1.0
// ============================================================================
module tb_dmem_stall_resp;

    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        stall, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        r1_valid, r1_we;
    logic [31:0] r1_addr, r1_wdata;
    logic [3:0]  r1_be;
    logic        s1_stall, s1_valid, s1_err;
    logic [31:0] s1_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_stall_resp #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .stall(stall), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_stall_resp #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(r1_valid), .req_we(r1_we), .req_addr(r1_addr),
        .req_wdata(r1_wdata), .req_be(r1_be),
        .stall(s1_stall), .resp_valid(s1_valid),
        .resp_rdata(s1_rdata), .resp_err(s1_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an access accepted in cycle t completes in cycle t+LAT, against a word-addressed memory.
    logic [31:0] m_mem [int];
    int          cyc = 0;
    int          m_done = 0;
    bit          m_pend = 0;
    bit          m_we;
    logic [31:0] m_addr, m_wdata, m_hold = 0;
    logic [3:0]  m_be;

    function automatic bit m_err();
        return (m_addr % 4 != 0) || ((m_addr / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] m_rdata();
        if (m_err() || m_we) return 32'h0;
        return m_mem[int'(m_addr / 4)];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pend = 0;
            m_hold = 0;
        end else if (m_pend && cyc == m_done) begin
            m_hold = m_rdata();
            if (m_we && !m_err()) begin
                logic [31:0] w;
                w = m_mem.exists(int'(m_addr / 4)) ? m_mem[int'(m_addr / 4)] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) w[b*8 +: 8] = m_wdata[b*8 +: 8];
                m_mem[int'(m_addr / 4)] = w;
            end
            m_pend = 0;
        end else if (!m_pend && req_valid) begin
            m_pend  = 1;
            m_done  = cyc + LAT;
            m_we    = req_we;
            m_addr  = req_addr;
            m_wdata = req_wdata;
            m_be    = req_be;
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit          ev, es;
        logic [31:0] er;
        ev = !rst && m_pend && (cyc == m_done);
        es = rst || (m_pend ? (cyc != m_done) : req_valid);
        er = rst ? 32'h0 : (ev ? m_rdata() : m_hold);
        chk("stall", {31'b0, stall}, {31'b0, es});
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
        chk("resp_rdata", resp_rdata, er);
        if (ev) chk("resp_err", {31'b0, resp_err}, {31'b0, m_err()});
    end

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit chg, input logic [31:0] chg_addr,
                          output logic [31:0] rd, output bit er, output int nst);
        bit got;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        nst = 0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1;
                break;
            end
            if (stall) nst++;
            @(posedge clk); #1;
            if (chg && nst == 1) req_addr = chg_addr;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: got no resp_valid expected one for addr %h", addr);
        end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic access1(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd);
        r1_valid = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_be = 4'hF;
        @(negedge clk);
        chk("l1_stall_req", {31'b0, s1_stall}, 32'd1);
        chk("l1_valid_req", {31'b0, s1_valid}, 32'd0);
        @(posedge clk); #1;
        r1_valid = 1'b0;
        @(negedge clk);
        chk("l1_valid_done", {31'b0, s1_valid}, 32'd1);
        chk("l1_stall_done", {31'b0, s1_stall}, 32'd0);
        rd = s1_rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        bit          er;
        int          nst;

        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
        r1_valid = 1'b0; r1_we = 1'b0; r1_addr = 32'h0; r1_wdata = 32'h0; r1_be = 4'h0;
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd1);
        chk("rst_rdata", resp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("idle_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;

        access(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, nst);
        chk("st_stalls", nst, 32'd3);
        access(0, 32'h10, 0, 4'h0, 0, 0, rd, er, nst);
        chk("ld_stalls", nst, 32'd3);
        chk("ld_10", rd, 32'hDEADBEEF);
        chk("ld_10_err", {31'b0, er}, 32'd0);

        access(1, 32'h20, 32'h11223344, 4'hF, 0, 0, rd, er, nst);
        access(1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, rd, er, nst);
        access(0, 32'h20, 0, 4'h0, 0, 0, rd, er, nst);
        chk("be_merge", rd, 32'h11BB33DD);

        access(0, 32'h22, 0, 4'hF, 0, 0, rd, er, nst);
        chk("mis_err", {31'b0, er}, 32'd1);
        chk("mis_rdata", rd, 32'h0);
        access(0, 32'(4 * DEPTH), 0, 4'hF, 0, 0, rd, er, nst);
        chk("oor_err", {31'b0, er}, 32'd1);
        access(1, 32'h22, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, nst);
        access(0, 32'h20, 0, 4'h0, 0, 0, rd, er, nst);
        chk("mis_store_nowrite", rd, 32'h11BB33DD);

        access(1, 32'h10, 32'h01020304, 4'h0, 0, 0, rd, er, nst);
        chk("be0_err", {31'b0, er}, 32'd0);
        access(1, 32'h30, 32'h30303030, 4'hF, 0, 0, rd, er, nst);
        access(0, 32'h10, 0, 4'h0, 1, 32'h30, rd, er, nst);
        chk("addr_change", rd, 32'hDEADBEEF);

        access(0, 32'h30, 0, 4'h0, 0, 0, rd, er, nst);
        chk("b2b_first_stalls", nst, 32'd3);
        access(0, 32'h30, 0, 4'h0, 0, 0, rd, er, nst);
        chk("b2b_second_stalls", nst, 32'd3);
        chk("b2b_second_rdata", rd, 32'h30303030);

        access(1, 32'h40, 32'h12345678, 4'hF, 0, 0, rd, er, nst);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_be = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midwait_rst_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0;
        access(0, 32'h40, 0, 4'h0, 0, 0, rd, er, nst);
        chk("abort_nowrite", rd, 32'h12345678);
        access(1, 32'h40, 32'h55, 4'hF, 0, 0, rd, er, nst);
        chk("reissue_stalls", nst, 32'd3);
        access(0, 32'h40, 0, 4'h0, 0, 0, rd, er, nst);
        chk("reissue_data", rd, 32'h00000055);

        access1(1, 32'h8, 32'hCAFEF00D, rd);
        access1(0, 32'h8, 32'h0, rd);
        chk("l1_load", rd, 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
